// File: rtl/prim_fifo_unpacker.sv
// prim_fifo_unpacker
//   Width-down converter for a synchronous FIFO read port. Each InW-bit word
//   accepted on the input handshake is held in a single register and replayed
//   as Ratio = InW/OutW narrower beats on the output handshake. The last beat
//   of one word and the load of the next share a cycle, so there are no
//   bubbles between words.
//
//   Optional build macro: PRIM_UNPACKER_LAST_EN
//     defined   : out_last_o port present (valid & final beat of the word)
//     undefined : port absent, consumers decode out_beat_o instead
//
// Ports
//   clk_i        clock, all state on the rising edge
//   rst_i        synchronous reset, active high (dominates clr_i)
//   clr_i        synchronous flush, drops the held word
//   in_valid_i   word available (FIFO rvalid)
//   in_ready_o   word accepted this cycle (FIFO rready)
//   in_data_i    input word (FIFO rdata)
//   out_valid_o  beat valid
//   out_ready_i  consumer accepts beat
//   out_data_o   beat data, zero while idle
//   out_last_o   final beat of the word (PRIM_UNPACKER_LAST_EN only)
//   out_beat_o   index of the current beat within the word
module prim_fifo_unpacker #(
   parameter int unsigned InW      = 32,
   parameter int unsigned OutW     = 8,
   parameter bit          MsbFirst = 1'b0,
   localparam int unsigned Ratio   = InW / OutW,
   localparam int unsigned CntW    = (Ratio == 1) ? 1 : $clog2(Ratio)
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            clr_i,
   input  logic            in_valid_i,
   output logic            in_ready_o,
   input  logic [InW-1:0]  in_data_i,
   output logic            out_valid_o,
   input  logic            out_ready_i,
   output logic [OutW-1:0] out_data_o,
`ifdef PRIM_UNPACKER_LAST_EN
   output logic            out_last_o,
`endif
   output logic [CntW-1:0] out_beat_o
);

   if (InW % OutW != 0) begin : g_bad_width
      $error("prim_fifo_unpacker: InW (%0d) must be a multiple of OutW (%0d)", InW, OutW);
   end

   logic [InW-1:0]  data_q, data_d;
   logic            valid_q, valid_d;
   logic [CntW-1:0] cnt_q, cnt_d;

   logic            last;
   logic            out_fire;
   logic            in_fire;
   logic [CntW-1:0] sel;
   logic [OutW-1:0] beat;

   assign last     = (cnt_q == CntW'(Ratio - 1));
   assign out_fire = valid_q & out_ready_i;

   // Ready depends only on state, clr and the consumer, never on in_valid_i,
   // so the FIFO side sees no combinational loop through this block.
   assign in_ready_o = ~rst_i & ~clr_i & (~valid_q | (out_fire & last));
   assign in_fire    = in_valid_i & in_ready_o;

   // Beat select: the counter always walks 0..Ratio-1; MsbFirst just mirrors
   // which slice of the held word that index maps to.
   always_comb begin
      sel  = MsbFirst ? (CntW'(Ratio - 1) - cnt_q) : cnt_q;
      beat = '0;
      for (int unsigned i = 0; i < Ratio; i++) begin
         if (sel == CntW'(i)) beat = data_q[i*OutW +: OutW];
      end
   end

   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      cnt_d   = cnt_q;
      if (clr_i) begin
         // A beat may still fire this cycle, but whatever remains is dropped.
         data_d  = '0;
         valid_d = 1'b0;
         cnt_d   = '0;
      end else if (in_fire) begin
         // Covers both an empty register and the last-beat/reload overlap.
         data_d  = in_data_i;
         valid_d = 1'b1;
         cnt_d   = '0;
      end else if (out_fire) begin
         if (last) begin
            valid_d = 1'b0;
            cnt_d   = '0;
         end else begin
            cnt_d = cnt_q + CntW'(1);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         data_q  <= '0;
         valid_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
         cnt_q   <= cnt_d;
      end
   end

   assign out_valid_o = valid_q;
   assign out_beat_o  = cnt_q;
   assign out_data_o  = valid_q ? beat : '0;
`ifdef PRIM_UNPACKER_LAST_EN
   assign out_last_o  = valid_q & last;
`endif

endmodule
